// File: rtl/alu_and_rf_pkg.sv
// Shared ALU control encodings for the MIPS-style datapath slice.
// Imported by the register file and by the ALU top.
package alu_and_rf_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b0010;
   localparam logic [3:0] FN_AND = 4'b0100;
   localparam logic [3:0] FN_OR  = 4'b0101;
   localparam logic [3:0] FN_NOR = 4'b0111;
   localparam logic [3:0] FN_SLT = 4'b1010;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_NOR,
      OP_SLT,
      OP_ZERO
   } alu_op_e;

endpackage

// File: rtl/alu_and_rf_regfile.sv
// 32x32 register file: two combinational reads, one write port.
// Async clear; register 0 is never written so it always reads 0.
module alu_and_rf_regfile
   import alu_and_rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] regs [2**ADDR_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // No bypass: a same-cycle read sees the pre-edge value.
   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_and_rf.sv
// Register file feeding a combinational 32-bit ALU.
// ALU control decode and datapath live here; storage is in the regfile.
module alu_and_rf
   import alu_and_rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Read1,
   input  logic [ADDR_W-1:0] Read2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [1:0]        RegWrite,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [3:0]        FuncCode,
   input  logic [1:0]        ALUOp,
   output logic [1:0]        Zero,
   output logic [DATA_W-1:0] ALUOut
);

   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   alu_op_e           op;

   alu_and_rf_regfile u_rf (
      .clk    (clk),
      .rst    (rst),
      .we     (RegWrite[0]),
      .waddr  (WriteReg),
      .wdata  (WriteData),
      .raddr1 (Read1),
      .raddr2 (Read2),
      .rdata1 (a),
      .rdata2 (b)
   );

   always_comb begin
      op = OP_ZERO;
      unique casez (ALUOp)
         ALUOP_ADD: op = OP_ADD;
         ALUOP_SUB: op = OP_SUB;
         2'b1?: begin
            case (FuncCode)
               FN_ADD:  op = OP_ADD;
               FN_SUB:  op = OP_SUB;
               FN_AND:  op = OP_AND;
               FN_OR:   op = OP_OR;
               FN_NOR:  op = OP_NOR;
               FN_SLT:  op = OP_SLT;
               default: op = OP_ZERO;
            endcase
         end
         default: op = OP_ZERO;
      endcase
   end

   always_comb begin
      ALUOut = '0;
      unique case (op)
         OP_ADD:  ALUOut = a + b;
         OP_SUB:  ALUOut = a - b;
         OP_AND:  ALUOut = a & b;
         OP_OR:   ALUOut = a | b;
         OP_NOR:  ALUOut = ~(a | b);
         OP_SLT:  ALUOut = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
         default: ALUOut = '0;
      endcase
   end

   assign Zero = {1'b0, ALUOut == '0};

endmodule

// File: tb/tb_alu_and_rf.sv
// Randomized self-checking bench for alu_and_rf.
// Reference: array register model plus arithmetic ALU function.
module tb_alu_and_rf;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  Read1, Read2, WriteReg;
   logic [1:0]  RegWrite;
   logic [31:0] WriteData;
   logic [3:0]  FuncCode;
   logic [1:0]  ALUOp;
   logic [1:0]  Zero;
   logic [31:0] ALUOut;

   int checks = 0;
   int errors = 0;
   logic [31:0] mdl [32];

   alu_and_rf dut (
      .clk       (clk),
      .rst       (rst),
      .Read1     (Read1),
      .Read2     (Read2),
      .WriteReg  (WriteReg),
      .RegWrite  (RegWrite),
      .WriteData (WriteData),
      .FuncCode  (FuncCode),
      .ALUOp     (ALUOp),
      .Zero      (Zero),
      .ALUOut    (ALUOut)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(
      input logic [1:0]  op,
      input logic [3:0]  fc,
      input logic [31:0] x,
      input logic [31:0] y
   );
      int sx, sy;
      sx = x;
      sy = y;
      if (op == 2'd0) return x + y;
      if (op == 2'd1) return x - y;
      case (fc)
         4'd0:    return x + y;
         4'd2:    return x - y;
         4'd4:    return x & y;
         4'd5:    return x | y;
         4'd7:    return ~(x | y);
         4'd10:   return (sx < sy) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic set_alu(
      input logic [4:0] r1,
      input logic [4:0] r2,
      input logic [1:0] op,
      input logic [3:0] fc
   );
      Read1 = r1;
      Read2 = r2;
      ALUOp = op;
      FuncCode = fc;
   endtask

   task automatic write_reg(input logic [4:0] wr, input logic [31:0] d);
      @(negedge clk);
      WriteReg = wr;
      WriteData = d;
      RegWrite = 2'b01;
      @(posedge clk);
      #1;
      RegWrite = 2'b00;
      if (wr != 0) mdl[wr] = d;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      RegWrite = 2'b00;
      WriteReg = '0;
      WriteData = '0;
      set_alu(5'd5, 5'd10, 2'b00, 4'd0);
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (ALUOut !== 32'h0 || Zero !== 2'b01) begin
         errors++;
         $display("FAIL reset_add: got %h/%b want 0/01", ALUOut, Zero);
      end
      for (int i = 0; i < 32; i++) begin
         set_alu(i[4:0], 5'd0, 2'b00, 4'd0);
         #1;
         checks++;
         if (ALUOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h want 0", i, ALUOut);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_writes;
      write_reg(5'd5, 32'h5555_5555);
      write_reg(5'd10, 32'hAAAA_AAAA);
      @(negedge clk);
      set_alu(5'd5, 5'd10, 2'b10, 4'b0000);
      #1;
      checks++;
      if (ALUOut !== 32'hFFFF_FFFF || Zero !== 2'b00) begin
         errors++;
         $display("FAIL write_add: got %h/%b want ffffffff/00", ALUOut, Zero);
      end
   endtask

   task automatic test_funcs;
      logic [3:0]  fcs [4];
      logic [31:0] exp [4];
      fcs = '{4'b0010, 4'b0100, 4'b0101, 4'b1010};
      exp = '{32'hAAAA_AAAB, 32'h0, 32'hFFFF_FFFF, 32'h0};
      for (int i = 0; i < 4; i++) begin
         set_alu(5'd5, 5'd10, 2'b10, fcs[i]);
         #1;
         checks++;
         if (ALUOut !== exp[i] || Zero !== {1'b0, exp[i] == 0}) begin
            errors++;
            $display("FAIL func_%b: got %h/%b want %h", fcs[i], ALUOut, Zero, exp[i]);
         end
      end
   endtask

   task automatic test_hold;
      logic [1:0] we [2];
      we = '{2'b00, 2'b10};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         WriteReg = 5'd5;
         WriteData = 32'h0;
         RegWrite = we[i];
         @(posedge clk);
         #1;
         RegWrite = 2'b00;
         set_alu(5'd5, 5'd0, 2'b00, 4'd0);
         #1;
         checks++;
         if (ALUOut !== 32'h5555_5555) begin
            errors++;
            $display("FAIL hold_we%b: got %h want 55555555", we[i], ALUOut);
         end
      end
   endtask

   task automatic test_r0;
      write_reg(5'd0, 32'h1234_5678);
      @(negedge clk);
      set_alu(5'd0, 5'd0, 2'b00, 4'd0);
      #1;
      checks++;
      if (ALUOut !== 32'h0 || Zero !== 2'b01) begin
         errors++;
         $display("FAIL r0_write: got %h/%b want 0/01", ALUOut, Zero);
      end
   endtask

   task automatic test_sub_unmapped;
      set_alu(5'd5, 5'd5, 2'b01, 4'd0);
      #1;
      checks++;
      if (ALUOut !== 32'h0 || Zero !== 2'b01) begin
         errors++;
         $display("FAIL sub_self: got %h/%b want 0/01", ALUOut, Zero);
      end
      set_alu(5'd5, 5'd10, 2'b10, 4'b1111);
      #1;
      checks++;
      if (ALUOut !== 32'h0 || Zero !== 2'b01) begin
         errors++;
         $display("FAIL unmapped: got %h/%b want 0/01", ALUOut, Zero);
      end
   endtask

   task automatic test_random;
      logic [31:0] exp;
      logic [4:0]  wr;
      logic [31:0] d;
      logic [1:0]  we;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         wr = 5'($urandom_range(0, 31));
         we = 2'($urandom_range(0, 3));
         d = (n % 7 == 0) ? 32'h8000_0000 : $urandom;
         WriteReg = wr;
         WriteData = d;
         RegWrite = we;
         set_alu(5'($urandom_range(0, 31)),
                 (n % 5 == 0) ? wr : 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)),
                 (n % 2 == 0) ? 4'($urandom_range(0, 15))
                              : 4'(2 * $urandom_range(0, 7)));
         #1;
         exp = ref_alu(ALUOp, FuncCode, mdl[Read1], mdl[Read2]);
         checks++;
         if (ALUOut !== exp || Zero !== {1'b0, exp == 0}) begin
            errors++;
            $display("FAIL rand%0d op%b fc%b r%0d r%0d: got %h/%b want %h",
                     n, ALUOp, FuncCode, Read1, Read2, ALUOut, Zero, exp);
         end
         @(posedge clk);
         if (we[0] && wr != 0) mdl[wr] = d;
      end
      @(negedge clk);
      RegWrite = 2'b00;
   endtask

   task automatic test_async_reset;
      write_reg(5'd7, 32'hDEAD_BEEF);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      set_alu(5'd7, 5'd0, 2'b00, 4'd0);
      #1;
      checks++;
      if (ALUOut !== 32'h0 || Zero !== 2'b01) begin
         errors++;
         $display("FAIL async_clear: got %h/%b want 0/01", ALUOut, Zero);
      end
      #1;
      rst = 1'b0;
      write_reg(5'd7, 32'h0000_0042);
      @(negedge clk);
      set_alu(5'd7, 5'd0, 2'b00, 4'd0);
      #1;
      checks++;
      if (ALUOut !== 32'h42) begin
         errors++;
         $display("FAIL post_reset_wr: got %h want 42", ALUOut);
      end
   endtask

   initial begin
      test_reset;
      test_writes;
      test_funcs;
      test_hold;
      test_r0;
      test_sub_unmapped;
      test_random;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
